dm_arbiter: RTL and testbench

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_arbiter.sv | 132 +++++++++++++
 tb/tb_dm_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - two-port round-robin data-memory arbiter with clear sweep
module dm_arbiter #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 15,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    input  logic              clr_start,
    output logic              busy,
    output logic              clr_done,
    output logic              dm_enable,
    output logic              dm_read,
    output logic              dm_write,
    output logic [ADDR_W-1:0] dm_address,
    output logic [DATA_W-1:0] dm_in,
    input  logic [DATA_W-1:0] dm_out
);

    typedef enum logic {CLEAR, ARB} state_t;

    localparam state_t            RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : ARB;
    localparam logic [ADDR_W-1:0] LAST_ADDR   = '1;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic              last_gnt;
    logic              rv0_q, rv1_q, done_q;
    logic              g0, g1;

    // last_gnt names the port that won most recently; a tie goes to the other one
    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (!rst && state == ARB && !clr_start) begin
            if (p0_req && p1_req) begin
                g0 = last_gnt;
                g1 = ~last_gnt;
            end else begin
                g0 = p0_req;
                g1 = p1_req;
            end
        end
    end

    always_comb begin
        dm_enable  = 1'b0;
        dm_read    = 1'b0;
        dm_write   = 1'b0;
        dm_address = '0;
        dm_in      = '0;
        if (!rst && state == CLEAR) begin
            dm_enable  = 1'b1;
            dm_write   = 1'b1;
            dm_address = cnt;
        end else if (g0) begin
            dm_enable  = 1'b1;
            dm_read    = ~p0_we;
            dm_write   = p0_we;
            dm_address = p0_addr;
            dm_in      = p0_wdata;
        end else if (g1) begin
            dm_enable  = 1'b1;
            dm_read    = ~p1_we;
            dm_write   = p1_we;
            dm_address = p1_addr;
            dm_in      = p1_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RESET_STATE;
            cnt      <= '0;
            last_gnt <= 1'b1;
            rv0_q    <= 1'b0;
            rv1_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            rv0_q  <= g0 & ~p0_we;
            rv1_q  <= g1 & ~p1_we;
            done_q <= 1'b0;
            if (g0) begin
                last_gnt <= 1'b0;
            end else if (g1) begin
                last_gnt <= 1'b1;
            end
            case (state)
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_ADDR) begin
                        state  <= ARB;
                        done_q <= 1'b1;
                        cnt    <= '0;
                    end
                end
                ARB: begin
                    if (clr_start) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end
                end
                default: state <= RESET_STATE;
            endcase
        end
    end

    // rst masks the registered outputs so they read 0 from the first reset cycle
    assign p0_gnt    = g0;
    assign p1_gnt    = g1;
    assign p0_rvalid = rv0_q & ~rst;
    assign p1_rvalid = rv1_q & ~rst;
    assign p0_rdata  = dm_out;
    assign p1_rdata  = dm_out;
    assign busy      = ~rst & (state == CLEAR);
    assign clr_done  = done_q & ~rst;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - directed scoreboard bench for dm_arbiter
module tb_dm_arbiter;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          p0_req = 1'b0, p0_we = 1'b0;
    logic [AW-1:0] p0_addr = '0;
    logic [DW-1:0] p0_wdata = '0;
    logic          p0_gnt, p0_rvalid;
    logic [DW-1:0] p0_rdata;
    logic          p1_req = 1'b0, p1_we = 1'b0;
    logic [AW-1:0] p1_addr = '0;
    logic [DW-1:0] p1_wdata = '0;
    logic          p1_gnt, p1_rvalid;
    logic [DW-1:0] p1_rdata;
    logic          clr_start = 1'b0;
    logic          busy, clr_done;
    logic          dm_enable, dm_read, dm_write;
    logic [AW-1:0] dm_address;
    logic [DW-1:0] dm_in;
    logic [DW-1:0] dm_out = '0;
    logic [DW-1:0] mem [16];

    typedef struct {
        int            port;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sbq[$];

    int n_cmp = 0;
    int n_err = 0;

    dm_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CLEAR_ON_RESET(1)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .clr_start(clr_start), .busy(busy), .clr_done(clr_done),
        .dm_enable(dm_enable), .dm_read(dm_read), .dm_write(dm_write),
        .dm_address(dm_address), .dm_in(dm_in), .dm_out(dm_out)
    );

    always #5 clk = ~clk;

    // Memory with one-cycle registered read, as the arbiter expects
    always @(posedge clk) begin
        if (dm_enable) begin
            if (dm_write) mem[dm_address] <= dm_in;
            if (dm_read)  dm_out <= mem[dm_address];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int port, input logic [DW-1:0] data);
        exp_t e;
        e.port = port;
        e.data = data;
        sbq.push_back(e);
    endtask

    task automatic drive(input int port, input logic req, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (port == 0) begin
            p0_req = req; p0_we = we; p0_addr = a; p0_wdata = d;
        end else begin
            p1_req = req; p1_we = we; p1_addr = a; p1_wdata = d;
        end
    endtask

    // Caller has already advanced to the negedge of the first sweep cycle
    task automatic sweep(input int n);
        for (int i = 0; i < n; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            chk("sweep_busy", busy, 1);
            chk("sweep_addr", dm_address, i);
            chk("sweep_ctl", {dm_enable, dm_write, dm_read}, 3'b110);
            chk("sweep_din", dm_in, 0);
            chk("sweep_nognt", {p1_gnt, p0_gnt}, 2'b00);
            chk("sweep_nodone", clr_done, 0);
        end
    endtask

    task automatic finish_sweep();
        @(negedge clk);
        p0_req = 1'b0;
        #1;
        chk("done_pulse", clr_done, 1);
        chk("done_busy", busy, 0);
        @(negedge clk);
        #1;
        chk("done_once", clr_done, 0);
        chk("idle_en", {dm_enable, dm_address, dm_in}, 0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                for (int p = 0; p < 2; p++) begin
                    if ((p == 0) ? p0_rvalid : p1_rvalid) begin
                        if (sbq.size() == 0) begin
                            chk("sb_unexpected_rvalid", p, 99);
                        end else begin
                            exp_t e;
                            e = sbq.pop_front();
                            chk("sb_port", p, e.port);
                            chk("sb_data", (p == 0) ? p0_rdata : p1_rdata, e.data);
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic all_zero;

        // Reset: outputs quiet even with a request pending
        p0_req = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_gnt", {p1_gnt, p0_gnt}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dm", {dm_enable, dm_read, dm_write, dm_address, dm_in}, 0);
        chk("rst_flags", {clr_done, p0_rvalid, p1_rvalid}, 0);
        chk("rst_rdata", p0_rdata, dm_out);

        // Clear sweep after reset, with p0 requesting throughout
        @(negedge clk);
        rst = 1'b0;
        sweep(16);
        finish_sweep();
        all_zero = 1'b1;
        for (int i = 0; i < 16; i++) if (mem[i] !== 32'h0) all_zero = 1'b0;
        chk("mem_cleared", all_zero, 1);

        // Both request continuously: p0, p1, p0, p1
        drive(0, 1, 0, 4'd0, 0);
        drive(1, 1, 0, 4'd0, 0);
        for (int k = 0; k < 4; k++) begin
            if (k != 0) @(negedge clk);
            #1;
            chk("rr_gnt", {p1_gnt, p0_gnt}, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk("rr_excl", dm_read & dm_write, 0);
            push(k % 2, 32'h0);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);

        // p0 writes 0xDEADBEEF to 3, then p1 reads it back
        @(negedge clk);
        drive(0, 1, 1, 4'd3, 32'hDEADBEEF);
        #1;
        chk("wr_gnt", {p1_gnt, p0_gnt}, 2'b01);
        chk("wr_dm", {dm_enable, dm_write, dm_read, dm_address, dm_in}, {3'b110, 4'd3, 32'hDEADBEEF});
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        drive(1, 1, 0, 4'd3, 0);
        #1;
        chk("rd_gnt", {p1_gnt, p0_gnt}, 2'b10);
        chk("rd_dm", {dm_enable, dm_write, dm_read, dm_address}, {3'b101, 4'd3});
        chk("wr_no_rvalid", p0_rvalid, 0);
        push(1, 32'hDEADBEEF);
        @(negedge clk);
        drive(1, 0, 0, 0, 0);
        #1;
        chk("rd_rvalid", {p1_rvalid, p0_rvalid}, 2'b10);
        chk("rd_rdata", p1_rdata, 32'hDEADBEEF);
        @(negedge clk);
        #1;
        chk("rd_pulse", p1_rvalid, 0);

        // Back-to-back p0 reads of 1 and 2
        drive(0, 1, 1, 4'd1, 32'h11111111);
        @(negedge clk);
        drive(0, 1, 1, 4'd2, 32'h22222222);
        @(negedge clk);
        drive(0, 1, 0, 4'd1, 0);
        #1;
        chk("b2b_gnt1", p0_gnt, 1);
        push(0, 32'h11111111);
        @(negedge clk);
        drive(0, 1, 0, 4'd2, 0);
        #1;
        chk("b2b_gnt2", p0_gnt, 1);
        chk("b2b_rv1", p0_rvalid, 1);
        push(0, 32'h22222222);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        #1;
        chk("b2b_rv2", p0_rvalid, 1);

        // clr_start right after a granted p1 read: rvalid still delivered
        @(negedge clk);
        drive(1, 1, 0, 4'd3, 0);
        #1;
        chk("clr_rd_gnt", p1_gnt, 1);
        push(1, 32'hDEADBEEF);
        @(negedge clk);
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, 4'd0, 0);
        clr_start = 1'b1;
        #1;
        chk("clr_start_nognt", {p1_gnt, p0_gnt, dm_enable}, 0);
        chk("clr_start_busy", busy, 0);
        chk("clr_rvalid", p1_rvalid, 1);
        @(negedge clk);
        clr_start = 1'b0;
        sweep(16);
        finish_sweep();
        chk("mem3_cleared", mem[3], 0);

        // Reset mid-read drops the pending rvalid
        @(negedge clk);
        drive(0, 1, 0, 4'd1, 0);
        #1;
        chk("mr_gnt", p0_gnt, 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        chk("mr_rvalid", p0_rvalid, 0);
        chk("mr_quiet", {busy, dm_enable}, 0);

        // Reset at clear address 7 restarts the sweep from 0
        @(negedge clk);
        rst = 1'b0;
        p0_req = 1'b1;
        sweep(8);
        rst = 1'b1;
        #1;
        chk("rst7_quiet", {busy, dm_enable, p0_gnt}, 0);
        @(negedge clk);
        rst = 1'b0;
        sweep(16);
        finish_sweep();

        repeat (3) @(negedge clk);
        chk("sb_empty", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
